multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Control unit that sequences the ARM-subset datapath as a multicycle machine. It runs one FSM pass per instruction, splitting it into fetch, decode, execute, memory and writeback steps. It holds the condition flags and gates every architectural write with the instruction's condition field. It sits beside the datapath, consumes Instr and ALUFlags, and drives all mux selects and write enables.

Parameters:
STATE_W, 4, width of the State debug output; the state encoding below fits in 4 bits

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
Instr  in  20  instruction bits [31:12] from the instruction register: cond[31:28], op[27:26], funct[25:20], Rd[15:12]
ALUFlags  in  4  {N,Z,C,V} from the ALU, current cycle
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address select: 0=PC, 1=ALU result register
MemWrite  out  1  data memory write enable
IRWrite  out  1  instruction register enable
RegWrite  out  1  register file write enable
RegSrc  out  2  [0]=1 reads R15 on RA1; [1]=1 reads Rd on RA2
ImmSrc  out  2  extend select; equals op
ALUSrcA  out  1  0=register A, 1=PC
ALUSrcB  out  2  00=register B, 01=ExtImm, 10=constant 4
ResultSrc  out  2  00=ALU output register, 01=read data register, 10=ALU result (direct)
ALUControl  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 ORR, 0100 EOR
State  out  STATE_W  current FSM state, for debug

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9. Encodings 10-15 are unused; any of them returns to FETCH.
- Transitions:
  - FETCH->DECODE.
  - DECODE: op=01 -> MEMADR; op=00 with funct[5]=0 -> EXECR; op=00 with funct[5]=1 -> EXECI; op=10 -> BRANCH; op=11 -> FETCH (undefined instruction, no effect).
  - MEMADR: funct[0]=1 -> MEMREAD, funct[0]=0 -> MEMWRITE.
  - MEMREAD->MEMWB->FETCH; MEMWRITE->FETCH; EXECR/EXECI->ALUWB->FETCH; BRANCH->FETCH.
- Per-state controls (any control not listed is 0):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1 unconditionally.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10.
  - MEMADR: ALUSrcB=01, ADD (offset always added).
  - MEMREAD and MEMWRITE: AdrSrc=1. MEMWRITE additionally drives MemWrite=CondEx.
  - MEMWB: ResultSrc=01, RegWrite=CondEx, PCWrite=CondEx&(Rd==15).
  - EXECR: ALUSrcB=00, ALUControl from cmd. EXECI: ALUSrcB=01, ALUControl from cmd.
  - ALUWB: ResultSrc=00, RegWrite=CondEx&~NoWrite, PCWrite=CondEx&~NoWrite&(Rd==15).
  - BRANCH: ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondEx.
- RegSrc and ImmSrc decode combinationally from Instr in every state:
  - RegSrc[0]=(op==10); RegSrc[1]=(op==01 & funct[0]==0); ImmSrc=op.
- cmd=funct[4:1] decode:
  - 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 0001 EOR.
  - 1010 CMP: SUB with NoWrite=1.
  - Any other cmd: ADD with NoWrite=1, and the flags are never updated.
- Condition evaluation:
  - CondEx is a register loaded at the end of DECODE from cond and the stored flags. Flag updates during execute therefore cannot affect the writeback of the same instruction.
  - EQ Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V; HI C&~Z; LS ~C|Z; GE N==V; LT N!=V; GT ~Z&(N==V); LE Z|(N!=V); AL 1; 1111 -> 0.
- Flags register update (end of EXECR/EXECI, only when funct[0]=1 and CondEx and cmd is supported):
  - N and Z are always loaded.
  - C and V are loaded only for ADD, SUB and CMP; logical operations keep the old C and V.
- Latency: data-processing 4 cycles, LDR 5, STR 4, B 3, undefined 2.
- Reset:
  - Asynchronous; State=FETCH, Flags=0000, CondEx=0.
  - While reset is high, PCWrite, IRWrite, RegWrite and MemWrite are forced 0. The other outputs take their FETCH values.
  - Reset mid-instruction abandons the instruction with no further writes. The first cycle after release is FETCH.

Test Plan:
- Reset, release, Instr=E0821003 (ADD R1,R2,R3) -> State 0,1,6,8,0; ALUControl=0000 in EXECR; RegWrite=1 only in ALUWB; PCWrite=1 only in FETCH.
- E3510005 (CMP R1,#5) with ALUFlags=0100 in EXECI, then 0A000002 (BEQ) -> RegWrite=0 in ALUWB; Z stored; BEQ sequence 0,1,9 with PCWrite=1 and RegSrc=01 in BRANCH.
- Z=1 stored, 1A000002 (BNE) -> PCWrite=0 in BRANCH; no other write enable asserted.
- E5910004 (LDR R0,[R1,#4]) -> State 0,1,2,3,4; AdrSrc=1 in MEMREAD; RegWrite=1 and ResultSrc=01 in MEMWB. E591F004 (LDR PC) -> PCWrite=1 in MEMWB.
- E5810004 (STR R0,[R1,#4]) -> RegSrc=10, MemWrite=1 only in MEMWRITE; 4 cycles total; RegWrite never 1.
- E0921003 (ADDS) -> flags loaded at end of EXECR. Assert reset mid-EXECR instead -> State=0 the same cycle, Flags=0000, no RegWrite pulse.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle control unit for the ARM-subset datapath: one FSM pass per instruction,
// condition flags, and condition-gated write enables. Controls are registered from the next state.
module multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:12]       Instr,
    input  logic [3:0]         ALUFlags,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic [1:0]         RegSrc,
    output logic [1:0]         ImmSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic [3:0]         ALUControl,
    output logic [STATE_W-1:0] State
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    typedef struct packed {
        logic       pcwrite;
        logic       adrsrc;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic [3:0] aluctl;
    } ctrl_t;

    localparam ctrl_t FETCH_CTRL = '{pcwrite: 1'b1, adrsrc: 1'b0, memwrite: 1'b0,
                                     irwrite: 1'b1, regwrite: 1'b0, alusrca: 1'b1,
                                     alusrcb: 2'b10, resultsrc: 2'b10, aluctl: 4'b0000};

    state_t     state, nstate;
    ctrl_t      ctrl, nctrl;
    logic [3:0] flags;
    logic       condex, condex_n, cond_ok;

    logic [3:0] cond, cmd, rd;
    logic [1:0] op;
    logic [5:0] funct;
    logic       rd15;
    logic       unused_rn;

    assign cond      = Instr[31:28];
    assign op        = Instr[27:26];
    assign funct     = Instr[25:20];
    assign rd        = Instr[15:12];
    assign cmd       = funct[4:1];
    assign rd15      = (rd == 4'hf);
    assign unused_rn = ^Instr[19:16];

    // cmd decode: unsupported commands behave as a silent ADD that never writes or sets flags
    logic [3:0] cmd_alu;
    logic       nowrite, supported, arith;

    always_comb begin
        cmd_alu   = 4'b0000;
        nowrite   = 1'b0;
        supported = 1'b1;
        arith     = 1'b0;
        case (cmd)
            4'b0100: begin cmd_alu = 4'b0000; arith = 1'b1; end
            4'b0010: begin cmd_alu = 4'b0001; arith = 1'b1; end
            4'b0000: cmd_alu = 4'b0010;
            4'b1100: cmd_alu = 4'b0011;
            4'b0001: cmd_alu = 4'b0100;
            4'b1010: begin cmd_alu = 4'b0001; arith = 1'b1; nowrite = 1'b1; end
            default: begin supported = 1'b0; nowrite = 1'b1; end
        endcase
    end

    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = flags;
        case (cond)
            4'b0000: cond_ok = z;
            4'b0001: cond_ok = ~z;
            4'b0010: cond_ok = c;
            4'b0011: cond_ok = ~c;
            4'b0100: cond_ok = n;
            4'b0101: cond_ok = ~n;
            4'b0110: cond_ok = v;
            4'b0111: cond_ok = ~v;
            4'b1000: cond_ok = c & ~z;
            4'b1001: cond_ok = ~c | z;
            4'b1010: cond_ok = (n == v);
            4'b1011: cond_ok = (n != v);
            4'b1100: cond_ok = ~z & (n == v);
            4'b1101: cond_ok = z | (n != v);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    // CondEx is captured only as DECODE ends, so execute-stage flag updates cannot leak into writeback
    assign condex_n = (state == DECODE) ? cond_ok : condex;

    always_comb begin
        nstate = FETCH;
        case (state)
            FETCH:  nstate = DECODE;
            DECODE: begin
                case (op)
                    2'b01:   nstate = MEMADR;
                    2'b00:   nstate = funct[5] ? EXECI : EXECR;
                    2'b10:   nstate = BRANCH;
                    default: nstate = FETCH;
                endcase
            end
            MEMADR:  nstate = funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD: nstate = MEMWB;
            EXECR:   nstate = ALUWB;
            EXECI:   nstate = ALUWB;
            default: nstate = FETCH;
        endcase
    end

    always_comb begin
        nctrl = '0;
        case (nstate)
            FETCH: nctrl = FETCH_CTRL;
            DECODE: begin
                nctrl.alusrca   = 1'b1;
                nctrl.alusrcb   = 2'b10;
                nctrl.resultsrc = 2'b10;
            end
            MEMADR:  nctrl.alusrcb = 2'b01;
            MEMREAD: nctrl.adrsrc  = 1'b1;
            MEMWRITE: begin
                nctrl.adrsrc   = 1'b1;
                nctrl.memwrite = condex_n;
            end
            MEMWB: begin
                nctrl.resultsrc = 2'b01;
                nctrl.regwrite  = condex_n;
                nctrl.pcwrite   = condex_n & rd15;
            end
            EXECR: nctrl.aluctl = cmd_alu;
            EXECI: begin
                nctrl.alusrcb = 2'b01;
                nctrl.aluctl  = cmd_alu;
            end
            ALUWB: begin
                nctrl.regwrite = condex_n & ~nowrite;
                nctrl.pcwrite  = condex_n & ~nowrite & rd15;
            end
            BRANCH: begin
                nctrl.alusrcb   = 2'b01;
                nctrl.resultsrc = 2'b10;
                nctrl.pcwrite   = condex_n;
            end
            default: nctrl = FETCH_CTRL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= FETCH;
            ctrl   <= FETCH_CTRL;
            flags  <= 4'b0000;
            condex <= 1'b0;
        end else begin
            state  <= nstate;
            ctrl   <= nctrl;
            condex <= condex_n;
            // logical ops refresh N/Z only; C/V come from the ALU just for arithmetic
            if ((state == EXECR || state == EXECI) && funct[0] && condex && supported) begin
                flags[3:2] <= ALUFlags[3:2];
                if (arith)
                    flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    assign PCWrite    = ctrl.pcwrite  & ~reset;
    assign IRWrite    = ctrl.irwrite  & ~reset;
    assign RegWrite   = ctrl.regwrite & ~reset;
    assign MemWrite   = ctrl.memwrite & ~reset;
    assign AdrSrc     = ctrl.adrsrc;
    assign ALUSrcA    = ctrl.alusrca;
    assign ALUSrcB    = ctrl.alusrcb;
    assign ResultSrc  = ctrl.resultsrc;
    assign ALUControl = ctrl.aluctl;
    assign RegSrc     = {(op == 2'b01) & ~funct[0], (op == 2'b10)};
    assign ImmSrc     = op;
    assign State      = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: instruction-level model of state walk, controls and flags,
// compared every cycle, plus literal checks on observed sequences and write pulses.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:12] Instr = '0;
    logic [3:0]  ALUFlags = '0;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0]  RegSrc, ImmSrc, ALUSrcB, ResultSrc;
    logic [3:0]  ALUControl;
    logic [3:0]  State;

    multicycle_controller #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .RegSrc(RegSrc), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUControl(ALUControl), .State(State)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    logic [3:0]  mflags = 4'b0000;
    logic [21:0] exp_vec;
    logic        exp_valid = 1'b0;
    logic [31:0] seq;
    int          npc, nrw, nmw;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // {supported, loads C/V, nowrite, alu[3:0]}
    function automatic logic [6:0] cmd_info(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return {3'b110, 4'd0};
            4'b0010: return {3'b110, 4'd1};
            4'b0000: return {3'b100, 4'd2};
            4'b1100: return {3'b100, 4'd3};
            4'b0001: return {3'b100, 4'd4};
            4'b1010: return {3'b111, 4'd1};
            default: return {3'b001, 4'd0};
        endcase
    endfunction

    // condition = base test on cond[3:1], inverted by cond[0]; AL/never handled separately
    function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return c[0] == 1'b0;
        endcase
        return base ^ c[0];
    endfunction

    function automatic logic [21:0] exp_out(input int s, input bit cx, input logic [31:0] w);
        logic pcw, adr, mw, irw, rw, asa;
        logic [1:0] asb, rs, rsrc, imm, op;
        logic [3:0] alu;
        logic [6:0] ci;
        op = w[27:26];
        ci = cmd_info(w[24:21]);
        {pcw, adr, mw, irw, rw, asa} = '0;
        asb = 2'b00; rs = 2'b00; alu = 4'b0000;
        rsrc = {op == 2'b01 && !w[20], op == 2'b10};
        imm = op;
        case (s)
            0: begin irw = 1; pcw = 1; asa = 1; asb = 2; rs = 2; end
            1: begin asa = 1; asb = 2; rs = 2; end
            2: asb = 1;
            3: adr = 1;
            4: begin rs = 1; rw = cx; pcw = cx && w[15:12] == 4'hf; end
            5: begin adr = 1; mw = cx; end
            6: alu = ci[3:0];
            7: begin asb = 1; alu = ci[3:0]; end
            8: begin rw = cx && !ci[4]; pcw = rw && w[15:12] == 4'hf; end
            9: begin asb = 1; rs = 2; pcw = cx; end
            default: ;
        endcase
        return {4'(s), pcw, adr, mw, irw, rw, rsrc, imm, asa, asb, rs, alu};
    endfunction

    always @(negedge clk) begin
        if (exp_valid) begin
            chk($sformatf("cycle_state%0d", exp_vec[21:18]),
                32'({State, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, RegSrc, ImmSrc,
                     ALUSrcA, ALUSrcB, ResultSrc, ALUControl}), 32'(exp_vec));
            seq = (seq << 4) | 32'(State);
            npc += int'(PCWrite);
            nrw += int'(RegWrite);
            nmw += int'(MemWrite);
        end
    end

    // Entered just after a clock edge with the DUT in FETCH; leaves the same way.
    task automatic run(input logic [31:0] w, input logic [3:0] af);
        int sts[$];
        bit cx;
        logic [6:0] ci;
        sts = {0, 1};
        case (w[27:26])
            2'b01: if (w[20]) sts.push_back(3); else sts.push_back(5);
            2'b00: sts.push_back(w[25] ? 7 : 6);
            2'b10: sts.push_back(9);
            default: ;
        endcase
        if (w[27:26] == 2'b01) begin
            sts.insert(2, 2);
            if (w[20]) sts.push_back(4);
        end
        if (w[27:26] == 2'b00) sts.push_back(8);
        cx = cond_pass(w[31:28], mflags);
        ci = cmd_info(w[24:21]);
        Instr = w[31:12];
        ALUFlags = af;
        seq = 0; npc = 0; nrw = 0; nmw = 0;
        foreach (sts[i]) begin
            exp_vec = exp_out(sts[i], cx, w);
            exp_valid = 1'b1;
            @(negedge clk);
            @(posedge clk);
            if ((sts[i] == 6 || sts[i] == 7) && w[20] && cx && ci[6]) begin
                mflags[3:2] = af[3:2];
                if (ci[5]) mflags[1:0] = af[1:0];
            end
            #1;
        end
        exp_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset = 1'b1;
        #3;
        chk("reset_outputs",
            32'({State, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, ALUSrcB, ResultSrc, ALUControl}),
            32'({4'd0, 5'b00000, 1'b1, 2'b10, 2'b10, 4'b0000}));
        @(posedge clk); #1 reset = 1'b0;
        mflags = 4'b0000;

        run(32'hE0821003, 4'b0000);  // ADD R1,R2,R3
        chk("add_seq", seq, 32'h0168); chk("add_regwrite", 32'(nrw), 1); chk("add_pcwrite", 32'(npc), 1);
        run(32'hE3510005, 4'b0100);  // CMP R1,#5 -> Z
        chk("cmp_seq", seq, 32'h0178); chk("cmp_regwrite", 32'(nrw), 0);
        run(32'h0A000002, 4'b0000);  // BEQ taken
        chk("beq_seq", seq, 32'h019); chk("beq_pcwrite", 32'(npc), 2);
        run(32'h1A000002, 4'b0000);  // BNE not taken
        chk("bne_pcwrite", 32'(npc), 1); chk("bne_writes", 32'(nrw + nmw), 0);
        run(32'hE5910004, 4'b0000);  // LDR R0,[R1,#4]
        chk("ldr_seq", seq, 32'h01234); chk("ldr_regwrite", 32'(nrw), 1);
        run(32'hE591F004, 4'b0000);  // LDR PC
        chk("ldrpc_pcwrite", 32'(npc), 2);
        run(32'hE5810004, 4'b0000);  // STR
        chk("str_seq", seq, 32'h0125); chk("str_memwrite", 32'(nmw), 1); chk("str_regwrite", 32'(nrw), 0);
        run(32'hE0421003, 4'b0000);  // SUB
        run(32'hE0221003, 4'b0000);  // EOR
        run(32'hE1821003, 4'b0000);  // ORR
        run(32'hE0921003, 4'b1010);  // ADDS -> N,C
        run(32'h4A000002, 4'b0000);  // BMI taken
        chk("bmi_pcwrite", 32'(npc), 2);
        run(32'h6A000002, 4'b0000);  // BVS not taken
        chk("bvs_pcwrite", 32'(npc), 1);
        run(32'hE0111003, 4'b0101);  // ANDS: N,Z loaded, C,V kept -> 0110
        run(32'h8A000002, 4'b0000);  // BHI not taken
        chk("bhi_pcwrite", 32'(npc), 1);
        run(32'h9A000002, 4'b0000);  // BLS taken
        chk("bls_pcwrite", 32'(npc), 2);
        run(32'hE1110003, 4'b1111);  // unsupported cmd with S: no flags, no write
        chk("tst_regwrite", 32'(nrw), 0);
        run(32'h0A000002, 4'b0000);  // BEQ still taken
        chk("beq2_pcwrite", 32'(npc), 2);
        run(32'h10821003, 4'b0000);  // ADDNE skipped
        chk("addne_regwrite", 32'(nrw), 0);
        run(32'h00821003, 4'b0000);  // ADDEQ executes
        chk("addeq_regwrite", 32'(nrw), 1);
        run(32'hF0821003, 4'b0000);  // never condition
        chk("never_regwrite", 32'(nrw), 0);
        run(32'hEC000000, 4'b0000);  // undefined op
        chk("und_seq", seq, 32'h01);

        // ADDS abandoned by reset in EXECR
        Instr = 20'hE0921;
        ALUFlags = 4'b1111;
        @(posedge clk); @(posedge clk); #2;
        chk("rst_mid_pre_state", 32'(State), 32'd6);
        reset = 1'b1;
        #1;
        chk("rst_mid_state", 32'(State), 32'd0);
        chk("rst_mid_writes", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'd0);
        @(negedge clk);
        chk("rst_mid_writes_hold", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        mflags = 4'b0000;
        run(32'h0A000002, 4'b0000);  // BEQ: Z cleared by reset
        chk("rst_beq_pcwrite", 32'(npc), 1);
        run(32'hAA000002, 4'b0000);  // BGE: N==V with cleared flags
        chk("rst_bge_pcwrite", 32'(npc), 2);
        run(32'hE0821003, 4'b0000);
        chk("post_rst_add_seq", seq, 32'h0168);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
